mem_stall_controller: RTL and testbench

//  Sequences the data-memory access of the instruction held in the EX/MEM pipeline register against a

---
 rtl/mem_stall_controller.sv | 91 +++++++++
 tb/tb_mem_stall_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_controller.sv
// mem_stall_controller: sequences the EX/MEM data-memory access over a req/ack bus and detects load-use hazards
module mem_stall_controller #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_shouldReadMemory,
    input  logic                 mem_shouldWriteMemory,
    input  logic [31:0]          mem_aluOutput,
    input  logic [31:0]          mem_registerRtOrZero,
    input  logic                 ex_shouldReadMemory,
    input  logic [4:0]           ex_registerWriteAddress,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [31:0]          dmem_rdata,
    output logic [31:0]          mem_readData,
    output logic                 hold_front,
    output logic                 hold_back,
    output logic                 bubble_idex,
    output logic                 bubble_memwb,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] stall_cycles
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} stateType;
    stateType state;
    logic [TW-1:0] timer;
    logic acc, memStall, loadUse;

    // memory stall has priority over load-use; controls forced low while reset is held
    always_comb begin
        acc = mem_shouldReadMemory | mem_shouldWriteMemory;
        memStall = (state == S_IDLE && acc) || state == S_WAIT || state == S_ERR;
        loadUse = ex_shouldReadMemory && ex_registerWriteAddress != 5'd0 &&
                  (ex_registerWriteAddress == id_rs || ex_registerWriteAddress == id_rt);
        hold_front = reset && (memStall || loadUse);
        hold_back = reset && memStall;
        bubble_memwb = reset && memStall;
        bubble_idex = reset && !memStall && loadUse;
    end

    // access sequencer: capture request, wait for ack or timeout, release for one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            timer <= '0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            mem_readData <= '0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (acc) begin
                    state <= S_WAIT;
                    timer <= '0;
                    dmem_req <= 1'b1;
                    dmem_we <= mem_shouldWriteMemory;
                    dmem_addr <= mem_aluOutput;
                    dmem_wdata <= mem_registerRtOrZero;
                end
                S_WAIT: if (dmem_ack) begin
                    state <= S_DONE;
                    dmem_req <= 1'b0;
                    mem_readData <= dmem_we ? mem_readData : dmem_rdata;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state <= S_ERR;
                    dmem_req <= 1'b0;
                    bus_error <= 1'b1;
                end else begin
                    timer <= timer + TW'(1);
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_ERR;
            endcase
        end
    end

    // saturating count of front-end stall cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_cycles <= '0;
        else if (hold_front && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_mem_stall_controller.sv
// tb_mem_stall_controller: scoreboard-driven checks of memory sequencing, hazards and timeout
module tb_mem_stall_controller;
    logic clock = 1'b0, reset = 1'b1;
    logic memRead = 0, memWrite = 0, exRead = 0, dmemAck = 0;
    logic [31:0] memAddr = 0, memWdata = 0, dmemRdata = 0;
    logic [4:0] exRd = 0, idRs = 0, idRt = 0;
    logic req, we, busErr;
    logic [31:0] addr, wdata, readData, stall;
    logic [3:0] ctrl;
    logic reqT, weT, busErrT;
    logic [31:0] addrT, wdataT, readDataT;
    logic [2:0] stallT;
    logic [3:0] ctrlT;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;} accType;
    accType expQ[$];
    accType a, b;
    logic [31:0] expRead;
    int tests = 0, fails = 0;

    always #5 clock = ~clock;

    mem_stall_controller dut (
        .clock(clock), .reset(reset),
        .mem_shouldReadMemory(memRead), .mem_shouldWriteMemory(memWrite),
        .mem_aluOutput(memAddr), .mem_registerRtOrZero(memWdata),
        .ex_shouldReadMemory(exRead), .ex_registerWriteAddress(exRd), .id_rs(idRs), .id_rt(idRt),
        .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata),
        .dmem_ack(dmemAck), .dmem_rdata(dmemRdata), .mem_readData(readData),
        .hold_front(ctrl[3]), .hold_back(ctrl[2]), .bubble_idex(ctrl[1]), .bubble_memwb(ctrl[0]),
        .bus_error(busErr), .stall_cycles(stall)
    );

    mem_stall_controller #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dutT (
        .clock(clock), .reset(reset),
        .mem_shouldReadMemory(memRead), .mem_shouldWriteMemory(memWrite),
        .mem_aluOutput(memAddr), .mem_registerRtOrZero(memWdata),
        .ex_shouldReadMemory(exRead), .ex_registerWriteAddress(exRd), .id_rs(idRs), .id_rt(idRt),
        .dmem_req(reqT), .dmem_we(weT), .dmem_addr(addrT), .dmem_wdata(wdataT),
        .dmem_ack(dmemAck), .dmem_rdata(dmemRdata), .mem_readData(readDataT),
        .hold_front(ctrlT[3]), .hold_back(ctrlT[2]), .bubble_idex(ctrlT[1]), .bubble_memwb(ctrlT[0]),
        .bus_error(busErrT), .stall_cycles(stallT)
    );

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        memRead = 1; exRead = 1; exRd = 3; idRs = 3;
        #1;
        tests++; if ({req, we, busErr} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {req, we, busErr}); end
        tests++; if ({addr, wdata, readData, stall} !== 128'd0) begin fails++; $display("FAIL reset_regs got %h want 0", {addr, wdata, readData, stall}); end
        tests++; if (ctrl !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got %b want 0000", ctrl); end
        cyc();
        memRead = 0; exRead = 0; exRd = 0; idRs = 0;
        reset = 1'b1;
        expRead = 32'd0;
        cyc();
    endtask

    task automatic test_load();
        cyc(); memRead = 1; memAddr = 32'h100;
        expQ.push_back('{1'b0, 32'h100, 32'h0, 32'hDEADBEEF});
        #1;
        tests++; if ({ctrl, req} !== 5'b11010) begin fails++; $display("FAIL load_idle got %b want 11010", {ctrl, req}); end
        cyc(); a = expQ.pop_front(); #1;
        tests++; if ({req, we, addr} !== {1'b1, a.we, a.addr}) begin fails++; $display("FAIL load_req got %h want %h", {req, we, addr}, {1'b1, a.we, a.addr}); end
        tests++; if (ctrl !== 4'b1101) begin fails++; $display("FAIL load_wait_ctrl got %b want 1101", ctrl); end
        dmemAck = 1; dmemRdata = a.rdata;
        cyc(); dmemAck = 0; dmemRdata = 0; memRead = 0; #1;
        expRead = a.rdata;
        tests++; if ({req, ctrl} !== 5'b00000) begin fails++; $display("FAIL load_done got %b want 00000", {req, ctrl}); end
        tests++; if (readData !== expRead) begin fails++; $display("FAIL load_data got %h want %h", readData, expRead); end
        tests++; if (stall !== 32'd2) begin fails++; $display("FAIL load_stall got %0d want 2", stall); end
        cyc(); #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL load_idle_after got %b want 0", req); end
    endtask

    task automatic test_store();
        cyc(); memWrite = 1; memRead = 1; memAddr = 32'h40; memWdata = 32'h1234;
        expQ.push_back('{1'b1, 32'h40, 32'h1234, 32'h0});
        #1;
        tests++; if (ctrl !== 4'b1101) begin fails++; $display("FAIL store_idle got %b want 1101", ctrl); end
        cyc(); a = expQ.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            #1;
            tests++; if ({req, we, addr, wdata} !== {1'b1, a.we, a.addr, a.wdata}) begin fails++; $display("FAIL store_req%0d got %h want %h", i, {req, we, addr, wdata}, {1'b1, a.we, a.addr, a.wdata}); end
            tests++; if (ctrl[2] !== 1'b1) begin fails++; $display("FAIL store_hold%0d got %b want 1", i, ctrl[2]); end
            if (i == 4) begin dmemAck = 1; dmemRdata = 32'hBAD0BAD0; end
        end
        cyc(); dmemAck = 0; dmemRdata = 0; memWrite = 0; memRead = 0; #1;
        tests++; if ({req, ctrl} !== 5'b00000) begin fails++; $display("FAIL store_done got %b want 00000", {req, ctrl}); end
        tests++; if (readData !== expRead) begin fails++; $display("FAIL store_data got %h want %h", readData, expRead); end
        tests++; if (stall !== 32'd8) begin fails++; $display("FAIL store_stall got %0d want 8", stall); end
    endtask

    task automatic test_load_use();
        cyc(); exRead = 1; exRd = 5; idRs = 5; idRt = 0; dmemAck = 1; dmemRdata = 32'hFFFFFFFF; #1;
        tests++; if ({ctrl, req} !== 5'b10100) begin fails++; $display("FAIL lu_rs got %b want 10100", {ctrl, req}); end
        cyc(); exRead = 0; dmemAck = 0; dmemRdata = 0; #1;
        tests++; if ({ctrl, req} !== 5'b00000) begin fails++; $display("FAIL lu_clear got %b want 00000", {ctrl, req}); end
        tests++; if (readData !== expRead) begin fails++; $display("FAIL lu_idle_ack got %h want %h", readData, expRead); end
        cyc(); exRead = 1; exRd = 0; idRs = 0; #1;
        tests++; if (ctrl !== 4'b0000) begin fails++; $display("FAIL lu_r0 got %b want 0000", ctrl); end
        cyc(); exRd = 7; idRs = 1; idRt = 7; #1;
        tests++; if (ctrl !== 4'b1010) begin fails++; $display("FAIL lu_rt got %b want 1010", ctrl); end
        cyc(); exRead = 0; exRd = 0; idRs = 0; idRt = 0; #1;
        tests++; if (stall !== 32'd10) begin fails++; $display("FAIL lu_stall got %0d want 10", stall); end
    endtask

    task automatic test_lu_with_mem();
        cyc(); memRead = 1; memAddr = 32'h80; exRead = 1; exRd = 9; idRs = 9;
        expQ.push_back('{1'b0, 32'h80, 32'h0, 32'hCAFEF00D});
        #1;
        tests++; if (ctrl !== 4'b1101) begin fails++; $display("FAIL lumem_idle got %b want 1101", ctrl); end
        cyc(); a = expQ.pop_front(); #1;
        tests++; if ({req, addr, ctrl} !== {1'b1, a.addr, 4'b1101}) begin fails++; $display("FAIL lumem_wait got %h want %h", {req, addr, ctrl}, {1'b1, a.addr, 4'b1101}); end
        dmemAck = 1; dmemRdata = a.rdata;
        cyc(); dmemAck = 0; dmemRdata = 0; memRead = 0; #1;
        expRead = a.rdata;
        tests++; if ({req, ctrl} !== 5'b01010) begin fails++; $display("FAIL lumem_done got %b want 01010", {req, ctrl}); end
        tests++; if (readData !== expRead) begin fails++; $display("FAIL lumem_data got %h want %h", readData, expRead); end
        cyc(); exRead = 0; exRd = 0; idRs = 0; #1;
        tests++; if (stall !== 32'd13) begin fails++; $display("FAIL lumem_stall got %0d want 13", stall); end
    endtask

    task automatic test_back_to_back();
        cyc(); memRead = 1; memAddr = 32'h200;
        expQ.push_back('{1'b0, 32'h200, 32'h0, 32'h11111111});
        #1;
        tests++; if (ctrl !== 4'b1101) begin fails++; $display("FAIL b2b_idle0 got %b want 1101", ctrl); end
        cyc(); a = expQ.pop_front(); #1;
        tests++; if ({req, addr} !== {1'b1, a.addr}) begin fails++; $display("FAIL b2b_req0 got %h want %h", {req, addr}, {1'b1, a.addr}); end
        dmemAck = 1; dmemRdata = a.rdata;
        cyc(); dmemAck = 0; dmemRdata = 0; #1;
        tests++; if ({req, ctrl, readData} !== {5'b00000, a.rdata}) begin fails++; $display("FAIL b2b_done0 got %h want %h", {req, ctrl, readData}, {5'b00000, a.rdata}); end
        cyc(); memAddr = 32'h204;
        expQ.push_back('{1'b0, 32'h204, 32'h0, 32'h22222222});
        #1;
        tests++; if ({req, ctrl} !== 5'b01101) begin fails++; $display("FAIL b2b_idle1 got %b want 01101", {req, ctrl}); end
        cyc(); b = expQ.pop_front(); #1;
        tests++; if ({req, addr} !== {1'b1, b.addr}) begin fails++; $display("FAIL b2b_req1 got %h want %h", {req, addr}, {1'b1, b.addr}); end
        dmemAck = 1; dmemRdata = b.rdata;
        cyc(); dmemAck = 0; dmemRdata = 0; memRead = 0; #1;
        expRead = b.rdata;
        tests++; if ({req, ctrl, readData} !== {5'b00000, expRead}) begin fails++; $display("FAIL b2b_done1 got %h want %h", {req, ctrl, readData}, {5'b00000, expRead}); end
        cyc(); #1;
        tests++; if ({req, stall} !== {1'b0, 32'd17}) begin fails++; $display("FAIL b2b_stall got %h want %h", {req, stall}, {1'b0, 32'd17}); end
    endtask

    task automatic test_timeout();
        #1 reset = 1'b0; #1;
        tests++; if ({reqT, weT, busErrT, ctrlT, stallT, readDataT} !== 42'd0) begin fails++; $display("FAIL to_reset got %h want 0", {reqT, weT, busErrT, ctrlT, stallT, readDataT}); end
        cyc(); reset = 1'b1;
        cyc(); memRead = 1; memAddr = 32'h300;
        expQ.push_back('{1'b0, 32'h300, 32'h0, 32'h5A5A5A5A});
        #1;
        tests++; if (ctrlT !== 4'b1101) begin fails++; $display("FAIL to_idle got %b want 1101", ctrlT); end
        cyc(); a = expQ.pop_front();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #1;
            tests++; if ({reqT, busErrT, addrT} !== {2'b10, a.addr}) begin fails++; $display("FAIL to_ackwait%0d got %h want %h", i, {reqT, busErrT, addrT}, {2'b10, a.addr}); end
            if (i == 3) begin dmemAck = 1; dmemRdata = a.rdata; end
        end
        cyc(); dmemAck = 0; dmemRdata = 0; memRead = 0; #1;
        tests++; if ({reqT, busErrT, ctrlT, readDataT} !== {6'b000000, a.rdata}) begin fails++; $display("FAIL to_ack_wins got %h want %h", {reqT, busErrT, ctrlT, readDataT}, {6'b000000, a.rdata}); end
        tests++; if (stallT !== 3'd5) begin fails++; $display("FAIL to_stall5 got %0d want 5", stallT); end
        cyc(); memRead = 1; memAddr = 32'h304; #1;
        tests++; if (ctrlT !== 4'b1101) begin fails++; $display("FAIL to_idle2 got %b want 1101", ctrlT); end
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            tests++; if ({reqT, busErrT} !== 2'b10) begin fails++; $display("FAIL to_wait%0d got %b want 10", i, {reqT, busErrT}); end
        end
        cyc(); #1;
        tests++; if ({reqT, busErrT, ctrlT} !== 6'b011101) begin fails++; $display("FAIL to_err got %b want 011101", {reqT, busErrT, ctrlT}); end
        memRead = 0;
        repeat (3) cyc();
        #1;
        tests++; if ({reqT, busErrT, ctrlT, readDataT} !== {6'b011101, a.rdata}) begin fails++; $display("FAIL to_err_held got %h want %h", {reqT, busErrT, ctrlT, readDataT}, {6'b011101, a.rdata}); end
        tests++; if (stallT !== 3'd7) begin fails++; $display("FAIL to_stall_sat got %0d want 7", stallT); end
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL to_main_wait got %b want 1", req); end
        #1 reset = 1'b0; #1;
        tests++; if ({reqT, weT, busErrT, ctrlT, stallT, readDataT} !== 42'd0) begin fails++; $display("FAIL to_async_reset got %h want 0", {reqT, weT, busErrT, ctrlT, stallT, readDataT}); end
        tests++; if ({req, busErr, ctrl, stall} !== 38'd0) begin fails++; $display("FAIL to_main_abort got %h want 0", {req, busErr, ctrl, stall}); end
        cyc(); reset = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_load_use();
        test_lu_with_mem();
        test_back_to_back();
        test_timeout();
        tests++; if (expQ.size() !== 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", expQ.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
